dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and sequencer in front of the single-port data memory. It lets the pipeline's memory stage and a secondary requester (debug/DMA port) share the data memory. Core accesses win by default. A wait counter guarantees the secondary port is served within a bounded number of cycles by inserting a one-cycle core stall. It sits between the memory-stage control (RE/WE, ALU address, REG_B store data) and the data memory array, and it returns load data and stall status to the pipeline.

## Interface
Parameters:
- ADDR_W, 10, word-index width of the memory (depth 2**ADDR_W)
- DATA_W, 32, data word width
- MAX_WAIT, 4, max consecutive cycles a pending debug request may lose to the core (≥1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- c_re  in  1  core load request (memory-stage RE)
- c_we  in  1  core store request (memory-stage WE)
- c_addr  in  32  core word address (ALU result)
- c_wdata  in  DATA_W  core store data (REG_B)
- c_rdata  out  DATA_W  core load data
- c_stall  out  1  core access not performed this cycle; pipeline holds
- c_err  out  1  core address out of range; access suppressed
- d_req  in  1  debug request; held until d_gnt
- d_we  in  1  debug write (1) / read (0)
- d_addr  in  32  debug word address
- d_wdata  in  DATA_W  debug write data
- d_gnt  out  1  debug access performed this cycle
- d_rvalid  out  1  debug read data valid (registered)
- d_rdata  out  DATA_W  debug read data (registered)
- d_err  out  1  debug address out of range (registered, with d_rvalid timing)
- m_re, m_we  out  1  memory read/write enables
- m_addr  out  ADDR_W  memory word index
- m_wdata  out  DATA_W  memory write data
- m_rdata  in  DATA_W  memory combinational read data

## Operation
- Core request: c_req = c_re | c_we. If both are set, the request is treated as a write and also returns read data (c_rdata = m_rdata).
- Range check: an address is in range if bits [31:ADDR_W] = 0. An out-of-range access drives m_re = m_we = 0.
  - Core: c_err = 1 that cycle, c_rdata = 0, no stall.
  - Debug: the grant still completes (d_gnt = 1), and d_err = 1 with the d_rvalid timing.
- FSM states: ARB (reset state) and DBG.
- ARB:
  - Core only, or no request: the memory is driven by the core.
  - Debug only: the debug request is granted combinationally this cycle (d_gnt = 1, memory driven by debug, c_stall = 0).
  - Both, with wait_cnt < MAX_WAIT-1: the core wins and wait_cnt increments.
  - Both, with wait_cnt = MAX_WAIT-1: the core wins this cycle and the next state is DBG.
- DBG:
  - The memory is driven by debug, d_gnt = 1, and c_stall = c_req.
  - The next state is always ARB.
  - If d_req = 0 in DBG (protocol violation), there is no access, d_gnt = 0 and c_stall = 0.
- wait_cnt: width $clog2(MAX_WAIT+1). It clears on any d_gnt and on any cycle with d_req = 0, and saturates at MAX_WAIT-1.
- Debug read response:
  - A granted read captures m_rdata into d_rdata and sets d_rvalid = 1 for exactly one cycle.
  - d_rdata holds its value until the next granted debug read.
  - Writes produce no d_rvalid.
- The memory outputs are purely a mux of the selected requester. m_re and m_we are never asserted when nothing is granted.

## Timing
- Reset values: state = ARB, wait_cnt = 0, d_rvalid = 0, d_rdata = 0, d_err = 0. All combinational outputs are 0 under reset with inputs idle.
- Core access latency: 0 cycles (same-cycle c_rdata) unless stalled. A stall lasts exactly 1 cycle.
- Debug worst-case latency from d_req rise to d_gnt is MAX_WAIT cycles.
- d_rvalid asserts in the cycle after d_gnt.
- Back-to-back debug requests: after a DBG cycle, the core has priority again. A new contending debug request waits up to MAX_WAIT cycles.
- Reset asserted mid-DBG: the FSM returns to ARB immediately. The pending d_rvalid is cancelled and no write is lost or duplicated beyond the cycle already clocked.

## Test plan
- Reset and idle: hold rst_n = 0, then release with no requests → all outputs 0, m_re = m_we = 0, d_rvalid = 0.
- Core read/write:
  - Stimulus: c_we = 1, c_addr = 5, c_wdata = 0xDEADBEEF; next cycle c_re = 1, c_addr = 5 → m_we pulse at index 5, then c_rdata = 0xDEADBEEF, c_stall = 0 throughout.
- Debug alone:
  - Stimulus: d_req = 1, d_we = 0, d_addr = 5 with the core idle → d_gnt in the same cycle, d_rvalid = 1 next cycle with d_rdata = 0xDEADBEEF.
- Starvation bound (MAX_WAIT = 4):
  - Stimulus: c_re held high continuously, d_req raised at cycle 0.
  - Required response: the core wins cycles 0–3, cycle 4 is DBG with c_stall = 1 and d_gnt = 1, and the core resumes at cycle 5.
- Out-of-range:
  - Core: c_we = 1, c_addr = 0x400 → c_err = 1, no m_we.
  - Debug: d_addr = 0x800, read → d_gnt = 1, d_err = 1 and d_rvalid = 1 next cycle, no memory access.
- Reset mid-DBG: assert rst_n low during the DBG cycle → state = ARB, d_rvalid stays 0, c_stall = 0 after release.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the core memory stage and the debug port.
// Core wins by default; a bounded wait counter forces a one-cycle debug slot.
module dmem_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              c_re,
    input  logic              c_we,
    input  logic [31:0]       c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_stall,
    output logic              c_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              m_re,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata
);
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    typedef enum logic {ARB, DBG} state_t;

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic              c_req, c_in, d_in;
    logic              sel_core, sel_dbg;

    assign c_req = c_re | c_we;
    assign c_in  = (c_addr[31:ADDR_W] == '0);
    assign d_in  = (d_addr[31:ADDR_W] == '0);

    always_comb begin
        state_nxt = ARB;
        wait_nxt  = wait_cnt;
        sel_core  = 1'b0;
        sel_dbg   = 1'b0;
        c_stall   = 1'b0;
        unique case (state)
            ARB: begin
                if (d_req && !c_req) begin
                    sel_dbg = 1'b1;
                end else begin
                    sel_core = c_req;
                    if (d_req) begin
                        if (wait_cnt == WAIT_LAST) state_nxt = DBG;
                        else                       wait_nxt  = wait_cnt + WAIT_W'(1);
                    end
                end
            end
            DBG: begin
                // A dropped debug request here hands the slot back to the core.
                if (d_req) begin
                    sel_dbg = 1'b1;
                    c_stall = c_req;
                end else begin
                    sel_core = c_req;
                end
            end
            default: ;
        endcase
        if (sel_dbg || !d_req) wait_nxt = '0;
    end

    assign d_gnt   = sel_dbg;
    assign m_re    = sel_dbg ? (~d_we & d_in) : (sel_core & c_re & c_in);
    assign m_we    = sel_dbg ? ( d_we & d_in) : (sel_core & c_we & c_in);
    assign m_addr  = sel_dbg ? d_addr[ADDR_W-1:0] : c_addr[ADDR_W-1:0];
    assign m_wdata = sel_dbg ? d_wdata : c_wdata;
    assign c_err   = sel_core & ~c_in;
    assign c_rdata = (sel_core & c_re & c_in) ? m_rdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ARB;
            wait_cnt <= '0;
            d_rvalid <= 1'b0;
            d_rdata  <= '0;
            d_err    <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            d_rvalid <= sel_dbg & ~d_we;
            d_err    <= sel_dbg & ~d_in;
            if (sel_dbg && !d_we) d_rdata <= d_in ? m_rdata : '0;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model (shadow memory, loss count, pending response).
module tb_dmem_arbiter;
    localparam int ADDR_W   = 10;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 4;
    localparam int DEPTH    = 1 << ADDR_W;

    logic clk = 1'b0, rst_n = 1'b0;
    logic c_re = 0, c_we = 0, d_req = 0, d_we = 0;
    logic [31:0] c_addr = 0, d_addr = 0;
    logic [DATA_W-1:0] c_wdata = 0, d_wdata = 0;
    logic [DATA_W-1:0] c_rdata, d_rdata, m_wdata, m_rdata;
    logic c_stall, c_err, d_gnt, d_rvalid, d_err, m_re, m_we;
    logic [ADDR_W-1:0] m_addr;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] ref_mem [DEPTH];

    int checks = 0, errors = 0;

    // model state and expectations
    int lost;
    bit turn;
    bit exp_stall, exp_gnt, exp_cerr, exp_mre, exp_mwe, exp_rvalid, exp_derr;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_wdata, exp_crdata, exp_rdata;
    bit m_din;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .c_re(c_re), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_rdata(c_rdata), .c_stall(c_stall), .c_err(c_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .m_re(m_re), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    assign m_rdata = mem[m_addr];
    always @(posedge clk) if (m_we) mem[m_addr] <= m_wdata;

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return 32'h400 << $urandom_range(0, 21);
        return 32'($urandom_range(0, 15));
    endfunction

    task automatic model_reset();
        lost = 0; turn = 0;
        exp_rvalid = 0; exp_derr = 0; exp_rdata = '0;
    endtask

    // Who owns the memory this cycle: debug when it is debug's forced turn or
    // the core is idle; otherwise the core.
    task automatic model_eval();
        bit creq, cin, core_go;
        creq    = c_re | c_we;
        cin     = (c_addr >> ADDR_W) == 0;
        m_din   = (d_addr >> ADDR_W) == 0;
        exp_gnt = d_req && (turn || !creq);
        core_go = !exp_gnt && creq;
        exp_stall  = exp_gnt && creq;
        exp_cerr   = core_go && !cin;
        exp_mwe    = exp_gnt ? (d_we && m_din) : (core_go && c_we && cin);
        exp_mre    = exp_gnt ? (!d_we && m_din) : (core_go && c_re && cin);
        exp_addr   = exp_gnt ? d_addr[ADDR_W-1:0] : c_addr[ADDR_W-1:0];
        exp_wdata  = exp_gnt ? d_wdata : c_wdata;
        exp_crdata = (core_go && c_re && cin) ? ref_mem[c_addr[ADDR_W-1:0]] : '0;
    endtask

    task automatic model_commit();
        bit creq;
        creq = c_re | c_we;
        exp_rvalid = exp_gnt && !d_we;
        exp_derr   = exp_gnt && !m_din;
        if (exp_gnt && !d_we) exp_rdata = m_din ? ref_mem[d_addr[ADDR_W-1:0]] : '0;
        if (exp_mwe) ref_mem[exp_addr] = exp_wdata;
        if (exp_gnt || !d_req) lost = 0;
        else if (creq) lost++;
        turn = (lost == MAX_WAIT);
    endtask

    task automatic settle();
        #2;
        model_eval();
    endtask

    task automatic advance();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++; if (c_stall !== 0 || d_gnt !== 0 || c_err !== 0) begin errors++; $display("FAIL reset_ctl stall=%b gnt=%b err=%b want 0", c_stall, d_gnt, c_err); end
        checks++; if (m_re !== 0 || m_we !== 0) begin errors++; $display("FAIL reset_mem re=%b we=%b want 0", m_re, m_we); end
        checks++; if (d_rvalid !== 0 || d_err !== 0 || d_rdata !== 0) begin errors++; $display("FAIL reset_dbg rvalid=%b err=%b rdata=%h want 0", d_rvalid, d_err, d_rdata); end
        checks++; if (c_rdata !== 0) begin errors++; $display("FAIL reset_crdata got %h want 0", c_rdata); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
        checks++; if (m_re !== 0 || m_we !== 0 || c_stall !== 0 || d_gnt !== 0) begin errors++; $display("FAIL idle re=%b we=%b stall=%b gnt=%b want 0", m_re, m_we, c_stall, d_gnt); end
        checks++; if (d_rvalid !== 0) begin errors++; $display("FAIL idle_rvalid got %b want 0", d_rvalid); end
    endtask

    task automatic test_core_rw();
        c_we = 1; c_addr = 5; c_wdata = 32'hDEADBEEF;
        settle();
        checks++; if (m_we !== 1 || m_addr !== 5 || m_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL core_wr we=%b addr=%0d data=%h want 1 5 deadbeef", m_we, m_addr, m_wdata); end
        checks++; if (c_stall !== 0) begin errors++; $display("FAIL core_wr_stall got %b want 0", c_stall); end
        advance();
        c_we = 0; c_re = 1;
        settle();
        checks++; if (c_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL core_rd got %h want deadbeef", c_rdata); end
        checks++; if (m_re !== 1 || m_we !== 0 || c_stall !== 0) begin errors++; $display("FAIL core_rd_ctl re=%b we=%b stall=%b want 1 0 0", m_re, m_we, c_stall); end
        advance();
        c_re = 0;
    endtask

    task automatic test_debug_alone();
        d_req = 1; d_we = 0; d_addr = 5;
        settle();
        checks++; if (d_gnt !== 1 || m_re !== 1 || m_addr !== 5 || c_stall !== 0) begin errors++; $display("FAIL dbg_gnt gnt=%b re=%b addr=%0d stall=%b want 1 1 5 0", d_gnt, m_re, m_addr, c_stall); end
        advance();
        d_req = 0;
        checks++; if (d_rvalid !== 1 || d_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL dbg_rsp rvalid=%b rdata=%h want 1 deadbeef", d_rvalid, d_rdata); end
        settle();
        advance();
        checks++; if (d_rvalid !== 0) begin errors++; $display("FAIL dbg_rvalid_pulse got %b want 0", d_rvalid); end
    endtask

    task automatic test_starvation();
        c_re = 1; c_addr = 5;
        d_req = 1; d_we = 1; d_addr = 7; d_wdata = 32'h12345678;
        for (int i = 0; i < MAX_WAIT; i++) begin
            settle();
            checks++; if (d_gnt !== 0 || c_stall !== 0 || c_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL starve_c%0d gnt=%b stall=%b rdata=%h want 0 0 deadbeef", i, d_gnt, c_stall, c_rdata); end
            advance();
        end
        settle();
        checks++; if (d_gnt !== 1 || c_stall !== 1) begin errors++; $display("FAIL starve_dbg gnt=%b stall=%b want 1 1", d_gnt, c_stall); end
        checks++; if (m_we !== 1 || m_addr !== 7 || m_wdata !== 32'h12345678) begin errors++; $display("FAIL starve_wr we=%b addr=%0d data=%h want 1 7 12345678", m_we, m_addr, m_wdata); end
        advance();
        d_req = 0;
        settle();
        checks++; if (c_stall !== 0 || m_re !== 1 || c_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL starve_resume stall=%b re=%b rdata=%h want 0 1 deadbeef", c_stall, m_re, c_rdata); end
        checks++; if (d_rvalid !== 0) begin errors++; $display("FAIL starve_wr_rvalid got %b want 0", d_rvalid); end
        advance();
        c_re = 0;
    endtask

    task automatic test_out_of_range();
        c_we = 1; c_addr = 32'h400; c_wdata = 32'hA5A5A5A5;
        settle();
        checks++; if (c_err !== 1 || m_we !== 0 || c_stall !== 0) begin errors++; $display("FAIL core_oor err=%b we=%b stall=%b want 1 0 0", c_err, m_we, c_stall); end
        advance();
        c_we = 0; c_addr = 0;
        d_req = 1; d_we = 0; d_addr = 32'h800;
        settle();
        checks++; if (d_gnt !== 1 || m_re !== 0 || m_we !== 0) begin errors++; $display("FAIL dbg_oor gnt=%b re=%b we=%b want 1 0 0", d_gnt, m_re, m_we); end
        advance();
        d_req = 0;
        checks++; if (d_rvalid !== 1 || d_err !== 1) begin errors++; $display("FAIL dbg_oor_rsp rvalid=%b err=%b want 1 1", d_rvalid, d_err); end
        settle();
        advance();
        checks++; if (d_err !== 0) begin errors++; $display("FAIL dbg_oor_err_pulse got %b want 0", d_err); end
    endtask

    task automatic test_reset_mid_dbg();
        c_re = 1; c_addr = 5;
        d_req = 1; d_we = 0; d_addr = 5;
        for (int i = 0; i < MAX_WAIT; i++) begin
            settle();
            advance();
        end
        settle();
        checks++; if (d_gnt !== 1 || c_stall !== 1) begin errors++; $display("FAIL mid_dbg_enter gnt=%b stall=%b want 1 1", d_gnt, c_stall); end
        rst_n = 1'b0;
        #1;
        checks++; if (c_stall !== 0 || d_gnt !== 0) begin errors++; $display("FAIL mid_dbg_rst stall=%b gnt=%b want 0 0", c_stall, d_gnt); end
        c_re = 0; d_req = 0;
        @(posedge clk); #1;
        checks++; if (d_rvalid !== 0) begin errors++; $display("FAIL mid_dbg_rvalid got %b want 0", d_rvalid); end
        rst_n = 1'b1;
        model_reset();
        c_re = 1;
        settle();
        checks++; if (c_stall !== 0 || c_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL mid_dbg_after stall=%b rdata=%h want 0 deadbeef", c_stall, c_rdata); end
        advance();
        checks++; if (d_rvalid !== 0) begin errors++; $display("FAIL mid_dbg_after_rvalid got %b want 0", d_rvalid); end
        c_re = 0;
    endtask

    task automatic test_random();
        int  pend;
        bit  granted;
        pend = 0;
        for (int i = 0; i < 600; i++) begin
            if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req = 1; d_we = ($urandom_range(0, 1) == 1);
                d_addr = rand_addr(); d_wdata = $urandom; pend = 0;
            end
            c_re = ($urandom_range(0, 3) != 0);
            c_we = ($urandom_range(0, 3) == 0);
            c_addr = rand_addr(); c_wdata = $urandom;
            settle();
            checks++; if (c_stall !== exp_stall || d_gnt !== exp_gnt || c_err !== exp_cerr) begin errors++; $display("FAIL rnd%0d_ctl stall=%b gnt=%b err=%b want %b %b %b", i, c_stall, d_gnt, c_err, exp_stall, exp_gnt, exp_cerr); end
            checks++; if (m_re !== exp_mre || m_we !== exp_mwe) begin errors++; $display("FAIL rnd%0d_en re=%b we=%b want %b %b", i, m_re, m_we, exp_mre, exp_mwe); end
            checks++; if (c_rdata !== exp_crdata) begin errors++; $display("FAIL rnd%0d_crdata got %h want %h", i, c_rdata, exp_crdata); end
            if (exp_mre || exp_mwe) begin
                checks++; if (m_addr !== exp_addr) begin errors++; $display("FAIL rnd%0d_addr got %0d want %0d", i, m_addr, exp_addr); end
            end
            if (exp_mwe) begin
                checks++; if (m_wdata !== exp_wdata) begin errors++; $display("FAIL rnd%0d_wdata got %h want %h", i, m_wdata, exp_wdata); end
            end
            if (d_req && !d_gnt) pend++;
            if (d_req) begin
                checks++; if (pend > MAX_WAIT) begin errors++; $display("FAIL rnd%0d_latency waited %0d want <= %0d", i, pend, MAX_WAIT); end
            end
            granted = exp_gnt;
            advance();
            checks++; if (d_rvalid !== exp_rvalid || d_err !== exp_derr) begin errors++; $display("FAIL rnd%0d_rsp rvalid=%b err=%b want %b %b", i, d_rvalid, d_err, exp_rvalid, exp_derr); end
            checks++; if (d_rdata !== exp_rdata) begin errors++; $display("FAIL rnd%0d_rdata got %h want %h", i, d_rdata, exp_rdata); end
            if (granted) d_req = 0;
        end
        c_re = 0; c_we = 0; d_req = 0;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = '0;
            ref_mem[i] = '0;
        end
        model_reset();
        @(posedge clk); #1;
        test_reset();
        test_core_rw();
        test_debug_alone();
        test_starvation();
        test_out_of_range();
        test_reset_mid_dbg();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
